// File: rtl/vram_arbiter_if.sv
// Bundle of renderer, CPU and VRAM-side signals around vram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vram_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [15*NUM_REQ-1:0] req_addr_i;
  logic [NUM_REQ-1:0]    req_strobe_i;
  logic [NUM_REQ-1:0]    req_ack_o;
  logic [31:0]           req_data_o;

  logic [14:0]           cpu_addr_i;
  logic                  cpu_strobe_i;
  logic                  cpu_we_i;
  logic [31:0]           cpu_wdata_i;
  logic [3:0]            cpu_wmask_i;
  logic                  cpu_ack_o;
  logic [31:0]           cpu_rdata_o;

  logic [14:0]           mem_addr_o;
  logic                  mem_en_o;
  logic [3:0]            mem_we_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  req_addr_i, req_strobe_i,
    input  cpu_addr_i, cpu_strobe_i, cpu_we_i, cpu_wdata_i, cpu_wmask_i,
    input  mem_rdata_i,
    output req_ack_o, req_data_o, cpu_ack_o, cpu_rdata_o,
    output mem_addr_o, mem_en_o, mem_we_o, mem_wdata_o
  );

  modport master (
    output req_addr_i, req_strobe_i,
    output cpu_addr_i, cpu_strobe_i, cpu_we_i, cpu_wdata_i, cpu_wmask_i,
    output mem_rdata_i,
    input  req_ack_o, req_data_o, cpu_ack_o, cpu_rdata_o,
    input  mem_addr_o, mem_en_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/vram_arbiter.sv
// Pipelined VRAM port arbiter: round-robin renderers, CPU at lowest priority.
// Optional VRAM_ARB_CPU_GUARD_EN adds a CPU starvation guard (CPU_WAIT_MAX cycles).
module vram_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int RD_LATENCY   = 2,
  parameter int CPU_WAIT_MAX = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  vram_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int ID_W  = $clog2(NUM_REQ + 1);
  localparam logic [ID_W-1:0] CPU_ID = ID_W'(NUM_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] pending_q;
  logic               cpu_pending_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  tag_t               tag_q [RD_LATENCY+1];

  logic [NUM_REQ-1:0] ack_q;
  logic [31:0]        req_data_q;
  logic               cpu_ack_q;
  logic [31:0]        cpu_rdata_q;
  logic               mem_en_q;
  logic [14:0]        mem_addr_q;
  logic [3:0]         mem_we_q;
  logic [31:0]        mem_wdata_q;

  logic [NUM_REQ-1:0] ren_elig;
  logic               cpu_elig;
  logic               cpu_force;
  logic               ren_hit;
  logic [PTR_W-1:0]   ren_idx;
  logic [PTR_W:0]     cand;
  logic               grant_cpu;
  logic               grant_ren;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_vec;
  logic [14:0]        grant_addr;
  logic [ID_W-1:0]    grant_id;
  tag_t               ret_tag;
  logic [NUM_REQ-1:0] ack_d;

  assign ren_elig = bus.req_strobe_i & ~pending_q;
  assign cpu_elig = bus.cpu_strobe_i & ~cpu_pending_q;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    ren_hit = 1'b0;
    ren_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!ren_hit && ren_elig[cand[PTR_W-1:0]]) begin
        ren_hit = 1'b1;
        ren_idx = cand[PTR_W-1:0];
      end
    end
  end

`ifdef VRAM_ARB_CPU_GUARD_EN
  localparam int WAIT_W = $clog2(CPU_WAIT_MAX + 1);
  logic [WAIT_W-1:0] wait_cnt_q;

  assign cpu_force = cpu_elig && (wait_cnt_q == WAIT_W'(CPU_WAIT_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i || grant_cpu) begin
      wait_cnt_q <= '0;
    end else if (cpu_elig && (wait_cnt_q != WAIT_W'(CPU_WAIT_MAX))) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  assign cpu_force = 1'b0;
`endif

  assign grant_cpu = cpu_elig && (cpu_force || !ren_hit);
  assign grant_ren = ren_hit && !grant_cpu;
  assign grant_any = grant_cpu || grant_ren;

  always_comb begin
    grant_vec = '0;
    if (grant_ren) grant_vec[ren_idx] = 1'b1;
  end

  always_comb begin
    grant_addr = bus.req_addr_i[15*ren_idx +: 15];
    grant_id   = ID_W'(ren_idx);
    if (grant_cpu) begin
      grant_addr = bus.cpu_addr_i;
      grant_id   = CPU_ID;
    end
  end

  // The oldest tag tells which port the data now on mem_rdata_i belongs to.
  assign ret_tag = tag_q[RD_LATENCY];

  always_comb begin
    ack_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ack_d[k] = ret_tag.valid && (ret_tag.id == ID_W'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      // NOTE: the tag pipeline must be reset so no ghost ack follows a reset; the data
      // registers are reset only because every output is required to read 0.
      pending_q     <= '0;
      cpu_pending_q <= 1'b0;
      rr_ptr_q      <= '0;
      for (int k = 0; k <= RD_LATENCY; k++) tag_q[k] <= '0;
      ack_q         <= '0;
      req_data_q    <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= '0;
      mem_wdata_q   <= '0;
    end else begin
      // Ack clears at the end of the ack cycle, so a still-held strobe is not regranted.
      pending_q     <= (pending_q & ~ack_q) | grant_vec;
      cpu_pending_q <= (cpu_pending_q & ~cpu_ack_q) | grant_cpu;

      if (grant_ren) begin
        rr_ptr_q <= (ren_idx == PTR_W'(NUM_REQ - 1)) ? '0 : ren_idx + 1'b1;
      end

      mem_en_q <= grant_any;
      mem_we_q <= '0;
      if (grant_any) mem_addr_q <= grant_addr;
      if (grant_cpu && bus.cpu_we_i) begin
        mem_we_q    <= bus.cpu_wmask_i;
        mem_wdata_q <= bus.cpu_wdata_i;
      end

      tag_q[0] <= '{valid: grant_any, id: grant_id};
      for (int k = 1; k <= RD_LATENCY; k++) tag_q[k] <= tag_q[k-1];

      ack_q     <= ack_d;
      cpu_ack_q <= ret_tag.valid && (ret_tag.id == CPU_ID);
      if (|ack_d) req_data_q <= bus.mem_rdata_i;
      if (ret_tag.valid && (ret_tag.id == CPU_ID)) cpu_rdata_q <= bus.mem_rdata_i;
    end
  end

  assign bus.req_ack_o   = ack_q;
  assign bus.req_data_o  = req_data_q;
  assign bus.cpu_ack_o   = cpu_ack_q;
  assign bus.cpu_rdata_o = cpu_rdata_q;
  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a VRAM model and requester drivers.
// Issues and acks are logged per cycle and compared against hand-derived cycles and data.
module tb_vram_arbiter;

  localparam int NR     = 6;
  localparam int RDL    = 2;
  localparam int CPU_ID = NR;

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  vram_arbiter_if #(.NUM_REQ(NR)) bus ();

  vram_arbiter #(
    .NUM_REQ     (NR),
    .RD_LATENCY  (RDL),
    .CPU_WAIT_MAX(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // VRAM model: unwritten words read as A500_0000 | address.
  logic [31:0] vram [logic [14:0]];
  logic [31:0] rd_pipe [RDL];

  function automatic logic [31:0] vram_rd(logic [14:0] a);
    if (vram.exists(a)) return vram[a];
    return 32'hA500_0000 | {17'h0, a};
  endfunction

  always @(posedge clk) begin
    logic [31:0] cur;
    if (bus.mem_en_o) begin
      cur = vram_rd(bus.mem_addr_o);
      rd_pipe[0] <= cur;
      if (|bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we_o[b]) cur[8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
        vram[bus.mem_addr_o] = cur;
      end
    end
    for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign bus.mem_rdata_i = rd_pipe[RDL-1];

  // Requester configuration (written by the test sequence only).
  logic [14:0] raddr  [NR] = '{default: '0};
  int          target [NR] = '{default: 0};
  logic [14:0] c_addr  = '0;
  logic        c_we    = 1'b0;
  logic [31:0] c_wdata = '0;
  logic [3:0]  c_mask  = '0;
  int          c_target = 0;

  // Driver-owned state and logs.
  int   done [NR] = '{default: 0};
  int   c_done = 0;
  iss_t iss_q [$];
  ack_t ack_q [$];

  initial begin
    iss_t ie;
    ack_t ae;
    bus.req_strobe_i = '0;
    bus.req_addr_i   = '0;
    bus.cpu_strobe_i = 1'b0;
    bus.cpu_addr_i   = '0;
    bus.cpu_we_i     = 1'b0;
    bus.cpu_wdata_i  = '0;
    bus.cpu_wmask_i  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_en_o) begin
        ie.cyc = cyc; ie.addr = bus.mem_addr_o; ie.we = bus.mem_we_o; ie.wdata = bus.mem_wdata_o;
        iss_q.push_back(ie);
      end
      for (int k = 0; k < NR; k++) begin
        if (bus.req_ack_o[k]) begin
          ae.cyc = cyc; ae.port = k; ae.data = bus.req_data_o;
          ack_q.push_back(ae);
        end
      end
      if (bus.cpu_ack_o) begin
        ae.cyc = cyc; ae.port = CPU_ID; ae.data = bus.cpu_rdata_o;
        ack_q.push_back(ae);
      end
      for (int k = 0; k < NR; k++) begin
        if (bus.req_strobe_i[k] && bus.req_ack_o[k]) begin
          bus.req_strobe_i[k] = 1'b0;
          done[k]++;
        end else if (!bus.req_strobe_i[k] && done[k] < target[k]) begin
          bus.req_addr_i[15*k +: 15] = raddr[k];
          bus.req_strobe_i[k] = 1'b1;
        end
      end
      if (bus.cpu_strobe_i && bus.cpu_ack_o) begin
        bus.cpu_strobe_i = 1'b0;
        c_done++;
      end else if (!bus.cpu_strobe_i && c_done < c_target) begin
        bus.cpu_addr_i   = c_addr;
        bus.cpu_we_i     = c_we;
        bus.cpu_wdata_i  = c_wdata;
        bus.cpu_wmask_i  = c_mask;
        bus.cpu_strobe_i = 1'b1;
      end
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic req(int k, logic [14:0] a, int n);
    raddr[k]  = a;
    target[k] = done[k] + n;
  endtask

  task automatic cpu_req(logic we, logic [14:0] a, logic [31:0] d, logic [3:0] m);
    c_we = we; c_addr = a; c_wdata = d; c_mask = m;
    c_target = c_done + 1;
  endtask

  function automatic iss_t iss_at(int i);
    iss_t e = '{cyc: -1, addr: '0, we: '0, wdata: '0};
    if (i < iss_q.size()) e = iss_q[i];
    return e;
  endfunction

  function automatic ack_t ack_at(int i);
    ack_t e = '{cyc: -1, port: -1, data: '0};
    if (i < ack_q.size()) e = ack_q[i];
    return e;
  endfunction

  int   t0, i0, a0, n_cpu, n_ren, cpu_cyc;
  iss_t ie;
  ack_t ae;
  logic [14:0] alt_addr [8] = '{15'h10, 15'h12, 15'h10, 15'h12, 15'h10, 15'h12, 15'h10, 15'h12};
  int          alt_cyc  [8] = '{1, 2, 6, 7, 11, 12, 16, 17};

  initial begin
    // Reset state
    rst = 1'b1;
    step(3);
    check("rst_mem_en",   bus.mem_en_o,    0);
    check("rst_mem_we",   bus.mem_we_o,    0);
    check("rst_mem_addr", bus.mem_addr_o,  0);
    check("rst_req_ack",  bus.req_ack_o,   0);
    check("rst_cpu_ack",  bus.cpu_ack_o,   0);
    check("rst_req_data", bus.req_data_o,  0);
    check("rst_cpu_data", bus.cpu_rdata_o, 0);
    rst = 1'b0;
    step(1);

    // Single renderer read
    i0 = iss_q.size(); a0 = ack_q.size();
    req(0, 15'h0123, 1); t0 = cyc;
    step(10);
    check("t1_n_issue", iss_q.size() - i0, 1);
    ie = iss_at(i0);
    check("t1_issue_cyc", ie.cyc - t0, 1);
    check("t1_issue_addr", ie.addr, 15'h0123);
    check("t1_issue_we", ie.we, 0);
    check("t1_n_ack", ack_q.size() - a0, 1);
    ae = ack_at(a0);
    check("t1_ack_cyc", ae.cyc - t0, 4);
    check("t1_ack_port", ae.port, 0);
    check("t1_ack_data", ae.data, 32'hA500_0123);

    // Four renderers at once
    do_reset();
    i0 = iss_q.size(); a0 = ack_q.size();
    for (int k = 0; k < 4; k++) req(k, 15'h0100 + 15'(k), 1);
    t0 = cyc;
    step(12);
    check("t2_n_issue", iss_q.size() - i0, 4);
    check("t2_n_ack", ack_q.size() - a0, 4);
    for (int k = 0; k < 4; k++) begin
      ie = iss_at(i0 + k);
      ae = ack_at(a0 + k);
      check($sformatf("t2_issue_cyc%0d", k), ie.cyc - t0, k + 1);
      check($sformatf("t2_issue_addr%0d", k), ie.addr, 15'h0100 + 15'(k));
      check($sformatf("t2_ack_cyc%0d", k), ae.cyc - t0, k + 4);
      check($sformatf("t2_ack_port%0d", k), ae.port, k);
      check($sformatf("t2_ack_data%0d", k), ae.data, 32'hA500_0100 + 32'(k));
    end

    // Renderers 0 and 2 re-strobing back to back
    do_reset();
    i0 = iss_q.size(); a0 = ack_q.size();
    req(0, 15'h10, 4); req(2, 15'h12, 4); t0 = cyc;
    step(24);
    check("t3_n_issue", iss_q.size() - i0, 8);
    for (int k = 0; k < 8; k++) begin
      ie = iss_at(i0 + k);
      check($sformatf("t3_issue_addr%0d", k), ie.addr, alt_addr[k]);
      check($sformatf("t3_issue_cyc%0d", k), ie.cyc - t0, alt_cyc[k]);
    end
    n_ren = 0;
    for (int i = a0; i < ack_q.size(); i++) if (ack_q[i].port == 1 || ack_q[i].port == 3) n_ren++;
    check("t3_acks_1_3", n_ren, 0);
    check("t3_n_ack", ack_q.size() - a0, 8);

    // CPU write, read-back, byte-masked write
    do_reset();
    i0 = iss_q.size(); a0 = ack_q.size();
    cpu_req(1'b1, 15'h7FFF, 32'hDEAD_BEEF, 4'hF); t0 = cyc;
    step(8);
    ie = iss_at(i0);
    ae = ack_at(a0);
    check("t4_wr_issue_cyc", ie.cyc - t0, 1);
    check("t4_wr_addr", ie.addr, 15'h7FFF);
    check("t4_wr_we", ie.we, 4'hF);
    check("t4_wr_wdata", ie.wdata, 32'hDEAD_BEEF);
    check("t4_wr_ack_cyc", ae.cyc - t0, 4);
    check("t4_wr_ack_port", ae.port, CPU_ID);
    i0 = iss_q.size(); a0 = ack_q.size();
    cpu_req(1'b0, 15'h7FFF, 32'h0, 4'h0); t0 = cyc;
    step(8);
    ie = iss_at(i0);
    ae = ack_at(a0);
    check("t4_rd_we", ie.we, 0);
    check("t4_rd_ack_cyc", ae.cyc - t0, 4);
    check("t4_rd_data", ae.data, 32'hDEAD_BEEF);
    cpu_req(1'b1, 15'h0050, 32'h1122_3344, 4'b0101);
    step(8);
    a0 = ack_q.size();
    cpu_req(1'b0, 15'h0050, 32'h0, 4'h0);
    step(8);
    ae = ack_at(a0);
    check("t4_mask_data", ae.data, 32'hA522_0044);

    // Saturated renderers plus one CPU read
    do_reset();
    a0 = ack_q.size();
    for (int k = 0; k < NR; k++) req(k, 15'h0300 + 15'(k), 5);
    cpu_req(1'b0, 15'h0400, 32'h0, 4'h0); t0 = cyc;
    step(50);
    n_cpu = 0; n_ren = 0; cpu_cyc = -1;
    for (int i = a0; i < ack_q.size(); i++) begin
      if (ack_q[i].port == CPU_ID) begin
        n_cpu++;
        cpu_cyc = ack_q[i].cyc - t0;
        check("t5_cpu_data", ack_q[i].data, 32'hA500_0400);
      end else begin
        n_ren++;
      end
    end
    check("t5_n_cpu_ack", n_cpu, 1);
    check("t5_n_ren_ack", n_ren, 30);
`ifdef VRAM_ARB_CPU_GUARD_EN
    check("t5_cpu_ack_cyc", cpu_cyc, 12);
`else
    check("t5_cpu_ack_cyc", cpu_cyc, 34);
`endif

    // Reset while renderer 1's access is in flight
    do_reset();
    i0 = iss_q.size(); a0 = ack_q.size();
    req(1, 15'h0201, 1); t0 = cyc;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_en_after_rst", bus.mem_en_o, 0);
    step(12);
    check("t6_n_issue", iss_q.size() - i0, 2);
    check("t6_issue0_cyc", iss_at(i0).cyc - t0, 1);
    check("t6_issue1_cyc", iss_at(i0 + 1).cyc - t0, 4);
    check("t6_issue1_addr", iss_at(i0 + 1).addr, 15'h0201);
    check("t6_n_ack", ack_q.size() - a0, 1);
    ae = ack_at(a0);
    check("t6_ack_cyc", ae.cyc - t0, 7);
    check("t6_ack_port", ae.port, 1);
    check("t6_ack_data", ae.data, 32'hA500_0201);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
